sw_ptr_bank: RTL and testbench

Passive PCIe TRN RX snooper that captures host writes to a bank of NUM_PTRS 64-bit software pointer registers in one BAR. It decodes 32- and 64-bit-address memory writes of 1 or 2 DW, byte-swaps the payload to host order, honours byte enables, and updates the selected slot. It sits alongside the other TRN RX consumers and drives the sw_ptr buses to the DMA engines.

---
 rtl/sw_ptr_bank.sv | 173 +++++++++++++++++
 tb/tb_sw_ptr_bank.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_ptr_bank.sv
// Passive TRN RX snooper: captures 1/2-DW host memory writes into NUM_PTRS 64-bit pointer slots.
// Define SW_PTR_BANK_UPD_STROBE_EN to enable the per-slot sw_ptr_upd pulses.
module sw_ptr_bank #(
    parameter int unsigned NUM_PTRS = 4,
    parameter int unsigned BAR_IDX  = 2,
    parameter logic [5:0]  BASE_DW  = 6'h10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [63:0]            trn_rd,
    input  logic [7:0]             trn_rrem_n,
    input  logic                   trn_rsof_n,
    input  logic                   trn_reof_n,
    input  logic                   trn_rsrc_rdy_n,
    input  logic [6:0]             trn_rbar_hit_n,
    output logic [64*NUM_PTRS-1:0] sw_ptr,
    output logic [NUM_PTRS-1:0]    sw_ptr_upd
);
    typedef enum logic [2:0] {IDLE, H32, D32, H64, D64, DROP} state_t;

    localparam logic [6:0] SPAN      = 7'(2 * NUM_PTRS);
    localparam logic [6:0] FMT_MWR32 = 7'b1000000;
    localparam logic [6:0] FMT_MWR64 = 7'b1100000;
    localparam logic [2:0] BAR_SEL   = 3'(BAR_IDX);

    state_t      state, state_n, cur;
    logic        len2_q, len2_n;
    logic [3:0]  fbe_q, fbe_n, lbe_q, lbe_n;
    logic [3:0]  slot_q, slot_n;
    logic        half_q, half_n;
    logic [31:0] data0_q, data0_n;

    logic        beat, sof, eof, hdr_ok, hit;
    logic [6:0]  fmt;
    logic [9:0]  len;
    logic [5:0]  addr, off;
    logic        commit, c_half;
    logic [3:0]  c_slot;
    logic [31:0] c_d0, c_d1;
    logic [7:0]  wmask;
    logic [63:0] wdata;
    logic        unused_ok;

    function automatic logic [31:0] swap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    assign beat   = !trn_rsrc_rdy_n;
    assign sof    = !trn_rsof_n;
    assign eof    = !trn_reof_n;
    // A SOF in any state abandons the current TLP and is decoded as a fresh header.
    assign cur    = sof ? IDLE : state;
    assign fmt    = trn_rd[62:56];
    assign len    = trn_rd[41:32];
    assign hdr_ok = !trn_rbar_hit_n[BAR_SEL] && (fmt == FMT_MWR32 || fmt == FMT_MWR64) &&
                    (len == 10'd1 || len == 10'd2);
    assign addr   = (cur == H32) ? trn_rd[39:34] : trn_rd[7:2];
    assign off    = addr - BASE_DW;
    assign hit    = (addr >= BASE_DW) && ({1'b0, off} < SPAN) && !(len2_q && addr[0]);

    always_comb begin
        state_n = state;
        len2_n  = len2_q;
        fbe_n   = fbe_q;
        lbe_n   = lbe_q;
        slot_n  = slot_q;
        half_n  = half_q;
        data0_n = data0_q;
        commit  = 1'b0;
        c_slot  = slot_q;
        c_half  = half_q;
        c_d0    = data0_q;
        c_d1    = '0;
        if (beat) begin
            unique case (cur)
                IDLE: if (sof) begin
                    len2_n = (len == 10'd2);
                    fbe_n  = trn_rd[3:0];
                    lbe_n  = trn_rd[7:4];
                    if (eof)
                        state_n = IDLE;
                    else if (hdr_ok)
                        state_n = (fmt == FMT_MWR64) ? H64 : H32;
                    else
                        state_n = DROP;
                end
                H32, H64: begin
                    slot_n  = off[4:1];
                    half_n  = addr[0];
                    data0_n = swap(trn_rd[31:0]);
                    if (!hit) begin
                        state_n = eof ? IDLE : DROP;
                    end else if (cur == H32 && !len2_q) begin
                        commit  = 1'b1;
                        c_slot  = off[4:1];
                        c_half  = addr[0];
                        c_d0    = swap(trn_rd[31:0]);
                        state_n = IDLE;
                    end else begin
                        state_n = eof ? IDLE : ((cur == H32) ? D32 : D64);
                    end
                end
                D32: begin
                    commit  = 1'b1;
                    c_d1    = swap(trn_rd[63:32]);
                    state_n = IDLE;
                end
                D64: begin
                    commit  = 1'b1;
                    c_d0    = swap(trn_rd[63:32]);
                    c_d1    = swap(trn_rd[31:0]);
                    state_n = IDLE;
                end
                DROP: if (eof) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
        if (len2_q) begin
            wmask = {lbe_q, fbe_q};
            wdata = {c_d1, c_d0};
        end else begin
            wmask = c_half ? {fbe_q, 4'h0} : {4'h0, fbe_q};
            wdata = {c_d0, c_d0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            len2_q  <= 1'b0;
            fbe_q   <= '0;
            lbe_q   <= '0;
            slot_q  <= '0;
            half_q  <= 1'b0;
            data0_q <= '0;
            sw_ptr  <= '0;
        end else begin
            state   <= state_n;
            len2_q  <= len2_n;
            fbe_q   <= fbe_n;
            lbe_q   <= lbe_n;
            slot_q  <= slot_n;
            half_q  <= half_n;
            data0_q <= data0_n;
            if (commit) begin
                for (int unsigned k = 0; k < NUM_PTRS; k++) begin
                    if (c_slot == 4'(k)) begin
                        for (int unsigned b = 0; b < 8; b++) begin
                            if (wmask[b]) sw_ptr[64*k + 8*b +: 8] <= wdata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

`ifdef SW_PTR_BANK_UPD_STROBE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_ptr_upd <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_PTRS; k++) begin
                sw_ptr_upd[k] <= commit && (c_slot == 4'(k));
            end
        end
    end
`else
    assign sw_ptr_upd = '0;
`endif

    assign unused_ok = ^{trn_rrem_n, trn_rbar_hit_n, off};

endmodule

// File: tb/tb_sw_ptr_bank.sv
// Randomized self-checking bench for sw_ptr_bank against a DW-addressed reference model.
`timescale 1ns/1ps
module tb_sw_ptr_bank;
    localparam int N    = 4;
    localparam int BAR  = 2;
    localparam int BASE = 16;
`ifdef SW_PTR_BANK_UPD_STROBE_EN
    localparam bit UPD_EN = 1'b1;
`else
    localparam bit UPD_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [63:0]     trn_rd;
    logic [7:0]      trn_rrem_n;
    logic            trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n;
    logic [6:0]      trn_rbar_hit_n;
    logic [64*N-1:0] sw_ptr;
    logic [N-1:0]    sw_ptr_upd;

    int              checks = 0;
    int              errors = 0;
    logic [64*N-1:0] m_ptr;
    logic [N-1:0]    exp_upd;

    always #5 clk = ~clk;

    sw_ptr_bank #(.NUM_PTRS(N), .BAR_IDX(BAR), .BASE_DW(6'(BASE))) dut (
        .clk(clk), .rst(rst), .trn_rd(trn_rd), .trn_rrem_n(trn_rrem_n),
        .trn_rsof_n(trn_rsof_n), .trn_reof_n(trn_reof_n), .trn_rsrc_rdy_n(trn_rsrc_rdy_n),
        .trn_rbar_hit_n(trn_rbar_hit_n), .sw_ptr(sw_ptr), .sw_ptr_upd(sw_ptr_upd)
    );

    // Payload DW j of a write lands at DW (addr+j) of the flat bank; PCIe byte i -> host byte i.
    function automatic int model_write(input int bar, input int len, input int addr,
                                       input logic [3:0] fbe, input logic [3:0] lbe,
                                       input logic [31:0] d0, input logic [31:0] d1);
        logic [31:0] d;
        logic [3:0]  be;
        if (bar != BAR || !(len == 1 || len == 2) || addr < BASE || addr + len > BASE + 2*N ||
            (len == 2 && addr % 2 == 1))
            return -1;
        for (int j = 0; j < len; j++) begin
            d  = (j == 0) ? d0 : d1;
            be = (j == 0) ? fbe : lbe;
            for (int i = 0; i < 4; i++)
                if (be[i]) m_ptr[(addr - BASE + j)*32 + 8*i +: 8] = d[31 - 8*i -: 8];
        end
        return (addr - BASE) / 2;
    endfunction

    function automatic logic [N-1:0] exp_of(input int slot);
        if (UPD_EN && slot >= 0) return N'(1) << slot;
        return '0;
    endfunction

    task automatic idle_inputs();
        trn_rsrc_rdy_n = 1'b1;
        trn_rd         = {$urandom, $urandom};
        trn_rsof_n     = 1'($urandom_range(1, 0));
        trn_reof_n     = 1'($urandom_range(1, 0));
        trn_rrem_n     = 8'($urandom);
    endtask

    task automatic beat(input logic sof, input logic eof, input logic [63:0] d);
        trn_rd         = d;
        trn_rsof_n     = !sof;
        trn_reof_n     = !eof;
        trn_rrem_n     = 8'($urandom);
        trn_rsrc_rdy_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            idle_inputs();
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic make_hdr(input bit is64, input int len, input logic [3:0] fbe,
                            input logic [3:0] lbe, output logic [63:0] h);
        h        = {$urandom, $urandom};
        h[62:56] = is64 ? 7'b1100000 : 7'b1000000;
        h[41:32] = 10'(len);
        h[7:4]   = lbe;
        h[3:0]   = fbe;
    endtask

    task automatic send_tlp(input bit is64, input int bar, input int len, input int addr,
                            input logic [3:0] fbe, input logic [3:0] lbe,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input int maxgap, output int slot);
        logic [63:0] h, b1, b2;
        int nbeats;
        make_hdr(is64, len, fbe, lbe, h);
        b1 = {$urandom, $urandom};
        b2 = {$urandom, $urandom};
        if (is64) begin
            b1[7:2] = 6'(addr);
            b2      = {d0, d1};
        end else begin
            b1[39:34]  = 6'(addr);
            b1[31:0]   = d0;
            b2[63:32]  = d1;
        end
        nbeats = (!is64 && len == 1) ? 2 : 3;
        trn_rbar_hit_n = ~(7'b1 << bar);
        beat(1'b1, 1'b0, h);
        gap(int'($urandom_range(maxgap, 0)));
        beat(1'b0, nbeats == 2, b1);
        if (nbeats == 3) begin
            gap(int'($urandom_range(maxgap, 0)));
            beat(1'b0, 1'b1, b2);
        end
        slot = model_write(bar, len, addr, fbe, lbe, d0, d1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        trn_rbar_hit_n = ~(7'b1 << BAR);
        repeat (3) beat(1'b1, 1'b0, {$urandom, $urandom});
        gap(2);
        checks++;
        if (sw_ptr !== '0) begin errors++; $display("FAIL reset_ptr: got %h expected 0", sw_ptr); end
        checks++;
        if (sw_ptr_upd !== '0) begin errors++; $display("FAIL reset_upd: got %b expected 0", sw_ptr_upd); end
        rst = 1'b0;
        m_ptr = '0;
        for (int c = 0; c < 4; c++) begin
            gap(1);
            checks++;
            if (sw_ptr_upd !== '0 || sw_ptr !== '0) begin
                errors++;
                $display("FAIL post_reset: upd %b ptr %h expected all 0", sw_ptr_upd, sw_ptr);
            end
        end
    endtask

    task automatic test_directed();
        int slot;
        send_tlp(1'b0, BAR, 2, 'h12, 4'hF, 4'hF, 32'h11223344, 32'h55667788, 0, slot);
        exp_upd = exp_of(slot);
        checks++;
        if (sw_ptr[127:64] !== 64'h8877665544332211) begin
            errors++; $display("FAIL mwr32_slot1: got %h expected 8877665544332211", sw_ptr[127:64]);
        end
        checks++;
        if (sw_ptr !== m_ptr) begin errors++; $display("FAIL mwr32_bank: got %h expected %h", sw_ptr, m_ptr); end
        checks++;
        if (sw_ptr_upd !== exp_upd) begin errors++; $display("FAIL mwr32_upd: got %b expected %b", sw_ptr_upd, exp_upd); end
        gap(1);
        checks++;
        if (sw_ptr_upd !== '0) begin errors++; $display("FAIL mwr32_pulse_width: got %b expected 0", sw_ptr_upd); end

        send_tlp(1'b0, BAR, 2, 'h16, 4'hF, 4'hF, $urandom, $urandom, 0, slot);
        gap(1);
        send_tlp(1'b1, BAR, 1, 'h17, 4'b0011, 4'($urandom), 32'hAABBCCDD, $urandom, 0, slot);
        exp_upd = exp_of(slot);
        checks++;
        if (sw_ptr[3*64+32 +: 16] !== 16'hBBAA) begin
            errors++; $display("FAIL mwr64_be_bytes: got %h expected bbaa", sw_ptr[3*64+32 +: 16]);
        end
        checks++;
        if (sw_ptr !== m_ptr) begin errors++; $display("FAIL mwr64_bank: got %h expected %h", sw_ptr, m_ptr); end
        checks++;
        if (sw_ptr_upd !== exp_upd) begin errors++; $display("FAIL mwr64_upd: got %b expected %b", sw_ptr_upd, exp_upd); end
        gap(1);
    endtask

    task automatic test_rejects();
        int bars [5]  = '{0, BAR, BAR, BAR, BAR};
        int lens [5]  = '{2, 2, 3, 2, 2};
        int addrs [5] = '{'h12, 'h08, 'h12, 'h13, 'h14};
        int slot;
        for (int t = 0; t < 5; t++) begin
            send_tlp(1'($urandom_range(1, 0)), bars[t], lens[t], addrs[t], 4'hF, 4'hF,
                     $urandom, $urandom, 0, slot);
            exp_upd = exp_of(slot);
            checks++;
            if (sw_ptr !== m_ptr || sw_ptr_upd !== exp_upd) begin
                errors++;
                $display("FAIL reject_%0d: ptr %h upd %b expected ptr %h upd %b",
                         t, sw_ptr, sw_ptr_upd, m_ptr, exp_upd);
            end
        end
        gap(1);
        checks++;
        if (sw_ptr_upd !== '0) begin errors++; $display("FAIL reject_tail_upd: got %b expected 0", sw_ptr_upd); end
    endtask

    task automatic test_gaps_and_reset();
        int slot;
        logic [63:0] h, b1;
        send_tlp(1'b1, BAR, 2, 'h18, 4'($urandom), 4'($urandom), $urandom, $urandom, 3, slot);
        exp_upd = exp_of(slot);
        checks++;
        if (sw_ptr !== m_ptr || sw_ptr_upd !== exp_upd) begin
            errors++;
            $display("FAIL gap_tlp: ptr %h upd %b expected ptr %h upd %b", sw_ptr, sw_ptr_upd, m_ptr, exp_upd);
        end
        gap(1);
        make_hdr(1'b0, 2, 4'hF, 4'hF, h);
        b1 = {$urandom, $urandom};
        b1[39:34] = 6'h10;
        beat(1'b1, 1'b0, h);
        beat(1'b0, 1'b0, b1);
        rst = 1'b1;
        gap(1);
        rst = 1'b0;
        beat(1'b0, 1'b1, {$urandom, $urandom});
        m_ptr = '0;
        checks++;
        if (sw_ptr !== m_ptr || sw_ptr_upd !== '0) begin
            errors++;
            $display("FAIL reset_mid_tlp: ptr %h upd %b expected all 0", sw_ptr, sw_ptr_upd);
        end
        gap(1);
        checks++;
        if (sw_ptr_upd !== '0) begin errors++; $display("FAIL reset_mid_tlp_upd: got %b expected 0", sw_ptr_upd); end
    endtask

    task automatic test_random();
        int slot, bar, len, addr;
        bit is64;
        logic [63:0] h;
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(7, 0) == 0) begin
                make_hdr(1'b0, 2, 4'hF, 4'hF, h);
                trn_rbar_hit_n = ~(7'b1 << BAR);
                beat(1'b1, 1'($urandom_range(1, 0)), h);
                gap(int'($urandom_range(1, 0)));
            end
            is64 = 1'($urandom_range(1, 0));
            bar  = ($urandom_range(9, 0) < 8) ? BAR : int'($urandom_range(6, 0));
            len  = ($urandom_range(9, 0) < 8) ? int'($urandom_range(2, 1))
                                              : ($urandom_range(1, 0) ? 3 : 0);
            addr = ($urandom_range(9, 0) < 7) ? BASE + int'($urandom_range(2*N - 1, 0))
                                              : int'($urandom_range(63, 0));
            send_tlp(is64, bar, len, addr, 4'($urandom), 4'($urandom), $urandom, $urandom,
                     int'($urandom_range(1, 0)) * 2, slot);
            exp_upd = exp_of(slot);
            checks++;
            if (sw_ptr !== m_ptr || sw_ptr_upd !== exp_upd) begin
                errors++;
                $display("FAIL random_%0d: ptr %h upd %b expected ptr %h upd %b",
                         t, sw_ptr, sw_ptr_upd, m_ptr, exp_upd);
            end
            if ($urandom_range(1, 0) == 1) begin
                gap(1);
                checks++;
                if (sw_ptr_upd !== '0) begin
                    errors++; $display("FAIL random_pulse_%0d: got %b expected 0", t, sw_ptr_upd);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        trn_rbar_hit_n = 7'h7F;
        m_ptr = '0;
        exp_upd = '0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_directed();
        test_rejects();
        test_gaps_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
